// File: rtl/hazard_scoreboard_if.sv
// hazard_scoreboard_if
// Bundles the ID-stage hazard query and the scoreboard's responses.
//   master : pipeline side. It drives the ID register addresses, Tuse/Tnew,
//            mul/div control and flush, and reads stall, the forward selects
//            and md_busy.
//   slave  : the scoreboard itself.
interface hazard_scoreboard_if #(
    parameter int unsigned NSTAGE = 3,
    parameter int unsigned TW     = 2,
    parameter int unsigned SW     = $clog2(NSTAGE + 1)
);
    logic [4:0]    ra1_id;
    logic [4:0]    ra2_id;
    logic [TW-1:0] tuse1_id;
    logic [TW-1:0] tuse2_id;
    logic [4:0]    wa_id;
    logic [TW-1:0] tnew_id;
    logic          md_use_id;
    logic          md_start;
    logic          md_div;
    logic          flush;
    logic          stall;
    logic [SW-1:0] fwd1_sel;
    logic [SW-1:0] fwd2_sel;
    logic          md_busy;

    modport master (
        output ra1_id, ra2_id, tuse1_id, tuse2_id, wa_id, tnew_id,
        output md_use_id, md_start, md_div, flush,
        input  stall, fwd1_sel, fwd2_sel, md_busy
    );

    modport slave (
        input  ra1_id, ra2_id, tuse1_id, tuse2_id, wa_id, tnew_id,
        input  md_use_id, md_start, md_div, flush,
        output stall, fwd1_sel, fwd2_sel, md_busy
    );
endinterface

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard
// Tracks in-flight register writers through NSTAGE post-ID stages and
// decrements their Tnew as they advance. From that state it produces the ID
// stall, the ID-stage forward selects and the mul/div busy interlock.
// Ports:
//   clk    : clock, rising edge
//   rst_n  : asynchronous active-low reset
//   sb_if  : hazard_scoreboard_if.slave
//            in : ra1_id, ra2_id, tuse1_id, tuse2_id, wa_id, tnew_id,
//                 md_use_id, md_start, md_div, flush
//            out: stall, fwd1_sel, fwd2_sel, md_busy
module hazard_scoreboard #(
    parameter int unsigned NSTAGE  = 3,
    parameter int unsigned TW      = 2,
    parameter int unsigned MUL_LAT = 5,
    parameter int unsigned DIV_LAT = 10,
    parameter int unsigned SW      = $clog2(NSTAGE + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    hazard_scoreboard_if.slave sb_if
);
    localparam int unsigned MaxLat = (DIV_LAT > MUL_LAT) ? DIV_LAT : MUL_LAT;
    localparam int unsigned CW     = $clog2(MaxLat + 1);

    // Stage k = 1 is EX. Index 0 is unused so that stage numbers line up.
    logic [4:0]    wa_q   [1:NSTAGE];
    logic [4:0]    wa_d   [1:NSTAGE];
    logic [TW-1:0] tnew_q [1:NSTAGE];
    logic [TW-1:0] tnew_d [1:NSTAGE];
    logic [CW-1:0] md_cnt_q, md_cnt_d;

    logic          hit1, hit2;
    logic [SW-1:0] hit1_stage, hit2_stage;
    logic [TW-1:0] hit1_tnew, hit2_tnew;
    logic          dstall1, dstall2;
    logic          md_busy;
    logic          stall;

    // Scan from oldest to youngest so that the youngest match is written last.
    // A younger writer therefore hides any older writer of the same register.
    always_comb begin
        hit1       = 1'b0;
        hit1_stage = '0;
        hit1_tnew  = '0;
        hit2       = 1'b0;
        hit2_stage = '0;
        hit2_tnew  = '0;
        for (int k = NSTAGE; k >= 1; k--) begin
            if (sb_if.ra1_id != 5'd0 && wa_q[k] == sb_if.ra1_id) begin
                hit1       = 1'b1;
                hit1_stage = SW'(k);
                hit1_tnew  = tnew_q[k];
            end
            if (sb_if.ra2_id != 5'd0 && wa_q[k] == sb_if.ra2_id) begin
                hit2       = 1'b1;
                hit2_stage = SW'(k);
                hit2_tnew  = tnew_q[k];
            end
        end
    end

    always_comb begin
        dstall1 = hit1 && (hit1_tnew > sb_if.tuse1_id);
        dstall2 = hit2 && (hit2_tnew > sb_if.tuse2_id);
        md_busy = (md_cnt_q != '0) || sb_if.md_start;
        stall   = dstall1 || dstall2 || (sb_if.md_use_id && md_busy);
    end

    // A match that is not ready yet and does not stall is left for the
    // downstream forwarding network, so the select stays at GRF (0).
    assign sb_if.fwd1_sel = (hit1 && hit1_tnew == '0) ? hit1_stage : '0;
    assign sb_if.fwd2_sel = (hit2 && hit2_tnew == '0) ? hit2_stage : '0;
    assign sb_if.stall    = stall;
    assign sb_if.md_busy  = md_busy;

    // Pipeline advance. Flush empties every stage, so the defaults are the
    // flushed state.
    always_comb begin
        for (int k = 1; k <= NSTAGE; k++) begin
            wa_d[k]   = '0;
            tnew_d[k] = '0;
        end
        if (!sb_if.flush) begin
            if (!stall) begin
                wa_d[1]   = sb_if.wa_id;
                tnew_d[1] = sb_if.tnew_id;
            end
            for (int k = 2; k <= NSTAGE; k++) begin
                wa_d[k]   = wa_q[k-1];
                tnew_d[k] = (tnew_q[k-1] != '0) ? tnew_q[k-1] - TW'(1) : '0;
            end
        end
    end

    // Mul/div occupancy. A flush cannot cancel a running operation, but a start
    // in a flushed cycle never really issued. A start while busy is ignored.
    always_comb begin
        md_cnt_d = md_cnt_q;
        if (sb_if.md_start && !sb_if.flush && md_cnt_q == '0) begin
            md_cnt_d = sb_if.md_div ? CW'(DIV_LAT) : CW'(MUL_LAT);
        end else if (md_cnt_q != '0) begin
            md_cnt_d = md_cnt_q - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 1; k <= NSTAGE; k++) begin
                wa_q[k]   <= '0;
                tnew_q[k] <= '0;
            end
            md_cnt_q <= '0;
        end else begin
            for (int k = 1; k <= NSTAGE; k++) begin
                wa_q[k]   <= wa_d[k];
                tnew_q[k] <= tnew_d[k];
            end
            md_cnt_q <= md_cnt_d;
        end
    end
endmodule

// File: tb/tb_hazard_scoreboard.sv
module tb_hazard_scoreboard;
    localparam int unsigned NSTAGE  = 3;
    localparam int unsigned TW      = 2;
    localparam int unsigned MUL_LAT = 5;
    localparam int unsigned DIV_LAT = 10;
    localparam int unsigned SW      = $clog2(NSTAGE + 1);
    localparam int          NVEC    = 28;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    hazard_scoreboard_if #(.NSTAGE(NSTAGE), .TW(TW), .SW(SW)) sb_if ();

    hazard_scoreboard #(
        .NSTAGE (NSTAGE),
        .TW     (TW),
        .MUL_LAT(MUL_LAT),
        .DIV_LAT(DIV_LAT),
        .SW     (SW)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .sb_if(sb_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int ra1, tu1, ra2, tu2, wa, tnew, md_use, md_start, md_div, flush;
        int e_stall, e_f1, e_f2, e_busy;
    } vec_t;

    vec_t vecs [NVEC];

    function automatic vec_t mk(input int ra1, tu1, ra2, tu2, wa, tnew,
                                input int md_use, md_start, md_div, flush,
                                input int e_stall, e_f1, e_f2, e_busy);
        vec_t r;
        r.ra1 = ra1; r.tu1 = tu1; r.ra2 = ra2; r.tu2 = tu2;
        r.wa = wa; r.tnew = tnew; r.md_use = md_use; r.md_start = md_start;
        r.md_div = md_div; r.flush = flush;
        r.e_stall = e_stall; r.e_f1 = e_f1; r.e_f2 = e_f2; r.e_busy = e_busy;
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic drive(input int ra1, tu1, ra2, tu2, wa, tnew,
                         input int md_use, md_start, md_div, flush);
        sb_if.ra1_id    = 5'(ra1);
        sb_if.tuse1_id  = TW'(tu1);
        sb_if.ra2_id    = 5'(ra2);
        sb_if.tuse2_id  = TW'(tu2);
        sb_if.wa_id     = 5'(wa);
        sb_if.tnew_id   = TW'(tnew);
        sb_if.md_use_id = md_use[0];
        sb_if.md_start  = md_start[0];
        sb_if.md_div    = md_div[0];
        sb_if.flush     = flush[0];
    endtask

    task automatic check_all(input string tag, input int st, f1, f2, bz);
        check({tag, " stall"},    32'(sb_if.stall),    st);
        check({tag, " fwd1_sel"}, 32'(sb_if.fwd1_sel), f1);
        check({tag, " fwd2_sel"}, 32'(sb_if.fwd2_sel), f2);
        check({tag, " md_busy"},  32'(sb_if.md_busy),  bz);
    endtask

    // md_start at cycle 0 with a dependent mul/div user held in ID.
    task automatic md_sequence(input int is_div, input int lat);
        for (int c = 0; c <= lat + 1; c++) begin
            drive(0, 0, 0, 0, 0, 0, 1, (c == 0) ? 1 : 0, is_div, 0);
            @(negedge clk);
            check($sformatf("md%0d c%0d stall", is_div, c), 32'(sb_if.stall),
                  (c <= lat) ? 1 : 0);
            check($sformatf("md%0d c%0d busy", is_div, c), 32'(sb_if.md_busy),
                  (c <= lat) ? 1 : 0);
            @(posedge clk); #1;
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        // ra1, tu1, ra2, tu2, wa, tnew, md_use, md_start, md_div, flush | stall, f1, f2, busy
        vecs[0]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0);
        // load-use: lw r1 (tnew 2) followed by a consumer with tuse 1
        vecs[1]  = mk(0, 0, 0, 0, 1, 2, 0, 0, 0, 0,  0, 0, 0, 0);
        vecs[2]  = mk(1, 1, 0, 0, 2, 1, 0, 0, 0, 0,  1, 0, 0, 0);
        vecs[3]  = mk(1, 1, 0, 0, 2, 1, 0, 0, 0, 0,  0, 0, 0, 0);
        vecs[4]  = mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0,  0, 3, 0, 0);
        vecs[5]  = mk(0, 0, 2, 0, 0, 0, 0, 0, 0, 0,  0, 0, 2, 0);
        // ALU to store: addu r3 (tnew 1), then sw reading r3 with tuse2 2
        vecs[6]  = mk(2, 0, 0, 0, 3, 1, 0, 0, 0, 0,  0, 3, 0, 0);
        vecs[7]  = mk(0, 0, 3, 2, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0);
        vecs[8]  = mk(0, 0, 3, 2, 0, 0, 0, 0, 0, 0,  0, 0, 2, 0);
        vecs[9]  = mk(0, 0, 3, 0, 0, 0, 0, 0, 0, 0,  0, 0, 3, 0);
        // shadowing: two writers of r5, the youngest wins
        vecs[10] = mk(0, 0, 0, 0, 5, 1, 0, 0, 0, 0,  0, 0, 0, 0);
        vecs[11] = mk(0, 0, 0, 0, 5, 0, 0, 0, 0, 0,  0, 0, 0, 0);
        vecs[12] = mk(5, 0, 5, 0, 0, 0, 0, 0, 0, 0,  0, 1, 1, 0);
        vecs[13] = mk(0, 0, 0, 0, 5, 2, 0, 0, 0, 0,  0, 0, 0, 0);
        vecs[14] = mk(5, 0, 0, 0, 0, 0, 0, 0, 0, 0,  1, 0, 0, 0);
        vecs[15] = mk(5, 0, 0, 0, 0, 0, 0, 0, 0, 0,  1, 0, 0, 0);
        vecs[16] = mk(5, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 3, 0, 0);
        // writes to $0 never match
        vecs[17] = mk(0, 0, 0, 0, 0, 2, 0, 0, 0, 0,  0, 0, 0, 0);
        vecs[18] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0);
        // mult start, then a load-use stall hit by a flush
        vecs[19] = mk(0, 0, 0, 0, 7, 2, 0, 1, 0, 0,  0, 0, 0, 1);
        vecs[20] = mk(7, 1, 0, 0, 0, 0, 0, 0, 0, 1,  1, 0, 0, 1);
        vecs[21] = mk(7, 1, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 1);
        // a start while busy is ignored, so busy falls on the original schedule
        vecs[22] = mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 0,  0, 0, 0, 1);
        vecs[23] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 1);
        vecs[24] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 1);
        vecs[25] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0);
        // a start together with a flush does not load the counter
        vecs[26] = mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 1,  0, 0, 0, 1);
        vecs[27] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0);

        repeat (2) @(posedge clk);
        @(negedge clk);
        check_all("in_reset", 0, 0, 0, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        for (int i = 0; i < NVEC; i++) begin
            drive(vecs[i].ra1, vecs[i].tu1, vecs[i].ra2, vecs[i].tu2, vecs[i].wa,
                  vecs[i].tnew, vecs[i].md_use, vecs[i].md_start, vecs[i].md_div,
                  vecs[i].flush);
            @(negedge clk);
            check_all($sformatf("vec%0d", i), vecs[i].e_stall, vecs[i].e_f1,
                      vecs[i].e_f2, vecs[i].e_busy);
            @(posedge clk); #1;
        end

        md_sequence(0, MUL_LAT);
        md_sequence(1, DIV_LAT);

        // Async reset in the middle of a divide with live forwarding.
        drive(0, 0, 0, 0, 9, 0, 0, 1, 1, 0);
        @(negedge clk);
        check_all("rst_a", 0, 0, 0, 1);
        @(posedge clk); #1;
        drive(9, 0, 9, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        check_all("rst_b", 0, 1, 1, 1);
        @(posedge clk); #1;
        @(negedge clk);
        check_all("rst_c", 0, 2, 2, 1);
        #2 rst_n = 1'b0;
        #1 check_all("rst_async", 0, 0, 0, 0);
        @(posedge clk); #1;
        check_all("rst_held", 0, 0, 0, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check_all("rst_nostale", 0, 0, 0, 0);
        @(posedge clk); #1;
        drive(0, 0, 0, 0, 9, 1, 0, 0, 0, 0);
        @(negedge clk);
        check_all("refill_a", 0, 0, 0, 0);
        @(posedge clk); #1;
        drive(9, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        check_all("refill_b", 0, 0, 0, 0);
        @(posedge clk); #1;
        @(negedge clk);
        check_all("refill_c", 0, 2, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
